// File: rtl/hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
//
// A free-running binary up-counter with a synchronous hold and an
// asynchronous clear. The memory models use it as a delay timer. The parent
// drives hold from &cntr, so the count stops at all-ones and marks
// "delay elapsed". The parent pulses reset low between accesses to start a
// new delay.
//
// Parameters:
//   SIZE   width of the count register in bits (>= 1); range 0 .. 2^SIZE-1
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-low clear; forces cntr to 0 immediately
//   hold   in   1: keep the current count on the edge; 0: increment
//   cntr   out  current count, driven straight from the register
// -----------------------------------------------------------------------------
module hold_counter #(
  parameter int SIZE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hold,
  output logic [SIZE-1:0] cntr
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0] cntr_reg;

  // The counter wraps modulo 2^SIZE because the MSB carry is dropped.
  // The counter does not saturate by itself; the parent does that
  // through hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cntr_reg <= '0;
    end else if (!hold) begin
      cntr_reg <= cntr_reg + ONE;
    end
  end

  assign cntr = cntr_reg;

endmodule

// File: tb/tb_hold_counter.sv
// -----------------------------------------------------------------------------
// tb_hold_counter
//
// Directed bench for hold_counter. It uses three instances: SIZE=4 (main
// behaviour), SIZE=1 and SIZE=8 (width corners). The 4-bit instance can have
// its hold input tied to &cntr, which is the parent's saturating hookup.
// -----------------------------------------------------------------------------
module tb_hold_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // SIZE=4 instance
  logic       reset4;
  logic       hold_dir;
  logic       sat_mode;
  logic       hold4;
  logic [3:0] cntr4;
  assign hold4 = sat_mode ? (&cntr4) : hold_dir;

  // SIZE=1 instance
  logic       reset1;
  logic       hold1;
  logic [0:0] cntr1;

  // SIZE=8 instance
  logic       reset8;
  logic       hold8;
  logic [7:0] cntr8;

  hold_counter #(.SIZE(4)) u_dut4 (
    .clock (clock),
    .reset (reset4),
    .hold  (hold4),
    .cntr  (cntr4)
  );

  hold_counter #(.SIZE(1)) u_dut1 (
    .clock (clock),
    .reset (reset1),
    .hold  (hold1),
    .cntr  (cntr1)
  );

  hold_counter #(.SIZE(8)) u_dut8 (
    .clock (clock),
    .reset (reset8),
    .hold  (hold8),
    .cntr  (cntr8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp4;
    int exp1;
    int exp8;

    reset4   = 1'b0;
    hold_dir = 1'b0;
    sat_mode = 1'b0;
    reset1   = 1'b0;
    hold1    = 1'b0;
    reset8   = 1'b0;
    hold8    = 1'b0;

    // Reset state: all counters read 0 while reset is low, even with hold=1.
    #2;
    check("reset4_init", int'(cntr4), 0);
    check("reset1_init", int'(cntr1), 0);
    check("reset8_init", int'(cntr8), 0);
    hold_dir = 1'b1;
    step();
    check("reset4_hold_hi", int'(cntr4), 0);
    hold_dir = 1'b0;
    step();
    check("reset4_hold_lo", int'(cntr4), 0);

    // Free count and wrap: the counter gives 1..15, 0, 1 over 17 edges.
    reset4 = 1'b1;
    exp4 = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      exp4 = (exp4 + 1) % 16;
      check($sformatf("wrap4_e%0d", i + 1), int'(cntr4), exp4);
    end

    // Asynchronous clear in the middle of a count.
    reset4 = 1'b0;
    #1;
    reset4 = 1'b1;
    check("clr_before_count", int'(cntr4), 0);
    for (int i = 0; i < 5; i++) step();
    check("count_to_5", int'(cntr4), 5);
    #2;                                  // between edges, well before the next one
    reset4 = 1'b0;
    #1;
    check("async_clear", int'(cntr4), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("held_in_reset_e%0d", i + 1), int'(cntr4), 0);
    end
    reset4 = 1'b1;
    step();
    check("first_after_release", int'(cntr4), 1);

    // Hold: count to 6, freeze for 4 edges, then resume.
    for (int i = 0; i < 5; i++) step();
    check("count_to_6", int'(cntr4), 6);
    hold_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold_e%0d", i + 1), int'(cntr4), 6);
    end
    hold_dir = 1'b0;
    step();
    check("resume_after_hold", int'(cntr4), 7);

    // Hold glitches between edges. hold is 0 at every rising edge, so the
    // counter must increment on every edge.
    exp4 = 7;
    for (int i = 0; i < 4; i++) begin
      hold_dir = 1'b1; #2;
      hold_dir = 1'b0; #1;
      hold_dir = 1'b1; #2;
      hold_dir = 1'b0;
      step();
      exp4 = exp4 + 1;
      check($sformatf("glitch_e%0d", i + 1), int'(cntr4), exp4);
    end

    // Saturating loop: hold = &cntr. The count reaches 15 after 15 edges and
    // then stays there.
    reset4 = 1'b0;
    #1;
    check("sat_clear", int'(cntr4), 0);
    reset4   = 1'b1;
    sat_mode = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("sat_climb_e%0d", i), int'(cntr4), i);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("sat_stay_e%0d", i + 1), int'(cntr4), 15);
    end
    reset4 = 1'b0;
    #1;
    check("sat_reset_pulse", int'(cntr4), 0);
    reset4 = 1'b1;
    step();
    check("sat_recount_1", int'(cntr4), 1);
    step();
    check("sat_recount_2", int'(cntr4), 2);
    sat_mode = 1'b0;

    // SIZE=1: the count toggles on every edge.
    reset1 = 1'b1;
    exp1 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp1 = exp1 ^ 1;
      check($sformatf("size1_e%0d", i + 1), int'(cntr1), exp1);
    end

    // SIZE=8: the count runs up to 255 and wraps to 0 on edge 256.
    reset8 = 1'b1;
    exp8 = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      exp8 = (exp8 + 1) % 256;
      if (i == 254 || i == 255)
        check($sformatf("size8_e%0d", i + 1), int'(cntr8), exp8);
      else if (int'(cntr8) !== exp8)
        check($sformatf("size8_e%0d", i + 1), int'(cntr8), exp8);
    end
    check("size8_wrapped", int'(cntr8), 0);
    step();
    check("size8_after_wrap", int'(cntr8), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so that the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
